exc_irq_controller: RTL and testbench
=====================================

// Module: exc_irq_controller
// PURPOSE
//  Multi-channel exception/interrupt sequencer for the LEGv8 pipeline.
//  - Latches N_IRQ external requests and arbitrates them against decoder-flagged synchronous exceptions.
//  - Drives Exc/EStatus to the datapath and holds the request until the pipeline acknowledges (ExcAck).
//  - Tracks handler occupancy until ERet.
//  - Successor to the single-IRQ combinational ack: adds per-channel pending latches, priority, handshake and a handler FSM.
// PARAMETERS
//  N_IRQ      4  number of external interrupt channels (1..2**(ESTATUS_W-1))
//  ESTATUS_W  4  EStatus width; MSB=1 marks IRQ, MSB=0 marks sync exception
// PORTS
//  clk        in   1          clock, all state on rising edge
//  reset      in   1          synchronous, active-low (reset==0 clears state)
//  ExtIRQ     in   N_IRQ      level interrupt requests, one per channel
//  SyncExc    in   1          decoder flags synchronous exception this cycle
//  SyncCode   in   ESTATUS_W  cause for SyncExc, MSB must be 0
//  ERet       in   1          ERET committed, handler exit
//  ExcAck     in   1          pipeline has redirected to exception vector
//  Exc        out  1          exception request to datapath
//  EStatus    out  ESTATUS_W  cause of current/last exception
//  ExtIAck    out  N_IRQ      one-hot 1-cycle ack to the serviced device
//  IrqId      out  $clog2(N_IRQ) (min 1)  channel being serviced
//  InHandler  out  1          1 while in HANDLER state
// BEHAVIOUR
//  Reset (reset==0 at clk edge): FSM=IDLE; pending=0; Exc=0; EStatus=0; ExtIAck=0; IrqId=0; InHandler=0.
//  Pending latch: pending[i] <= pending[i] | ExtIRQ[i] each cycle.
//  Pending clear: pending[i] is cleared in the cycle ExtIAck[i] is asserted; clear beats set in that cycle.
//  Devices must drop ExtIRQ[i] on ExtIAck[i], otherwise the channel is re-pended the following cycle.
//  Priority: SyncExc over any IRQ; among IRQs, lowest index wins.
//  FSM states IDLE, REQ, HANDLER; all outputs registered.
//   IDLE:
//    - SyncExc=1 -> REQ, EStatus<=SyncCode.
//    - else if |(pending|ExtIRQ) -> REQ, EStatus<={1'b1,id}, IrqId<=id.
//    - Exc=1 from the next cycle, so latency is 1 cycle.
//    - ERet and ExcAck are ignored in IDLE.
//   REQ:
//    - Exc held 1 and EStatus stable until ExcAck.
//    - ExcAck -> HANDLER, Exc<=0, InHandler<=1.
//    - If the cause was an IRQ, ExtIAck[IrqId]<=1 for exactly one cycle.
//    - New events arriving while in REQ only set pending; SyncExc is ignored.
//   HANDLER:
//    - No nesting: IRQs keep pending and SyncExc is ignored.
//    - ERet -> IDLE, InHandler<=0; EStatus/IrqId keep their last values.
//    - A pending IRQ is taken one cycle after IDLE is re-entered, never the same cycle as ERet.
//    - ExcAck is ignored in HANDLER.
//  Simultaneous SyncExc and IRQ in IDLE: sync taken, IRQ stays pending.
//  reset==0 in any state returns to the reset values; in-flight acks are lost and pending bits are dropped.
//  EStatus IRQ encoding: id zero-extended to ESTATUS_W-1 bits, MSB set.
// CONFIGURATION
//  IRQ_MASK_EN defined:
//   - Adds ports mask_we (in,1) and mask_wdata (in,N_IRQ).
//   - Mask register resets to all-ones (all enabled) and loads on mask_we.
//   - Arbitration uses pending&mask; masked channels still latch pending.
//   - A write takes effect for arbitration in the cycle after mask_we.
//  IRQ_MASK_EN undefined: no mask ports; every channel is always enabled.
// TESTING
//  1. Reset: hold reset=0 for 2 clk with ExtIRQ=4'hF -> all outputs 0, pending 0, FSM IDLE.
//  2. Single IRQ: ExtIRQ=4'b0100 for 1 cycle -> next cycle Exc=1, EStatus=4'b1010, IrqId=2.
//     ExcAck 3 cycles later -> Exc=0, ExtIAck=4'b0100 for one cycle, InHandler=1.
//     ERet -> InHandler=0.
//  3. Priority: SyncExc=1, SyncCode=4'h3 and ExtIRQ=4'b1010 in the same cycle -> EStatus=4'h3.
//     After the ERet -> IDLE transition, the next request is EStatus=4'b1001 (ch1), then ch3.
//  4. No nesting: ExtIRQ[0] pulse while InHandler=1 -> Exc stays 0.
//     Exc=1, EStatus=4'b1000 one cycle after returning to IDLE.
//  5. Reset mid-REQ: Exc=1, reset=0 for 1 cycle -> Exc=0, no ExtIAck pulse, pending cleared.
//  6. IRQ_MASK_EN: write mask=4'b1110, pulse ExtIRQ[0] -> no Exc.
//     Write mask=4'hF -> Exc=1, EStatus=4'b1000 one cycle after the write.

Source files
------------

// File: rtl/exc_irq_controller.sv
// Exception/interrupt sequencer: latches IRQs, arbitrates sync exceptions over IRQs, handshakes Exc/ExcAck, tracks handler until ERet.
// Latency: 1 cycle from request to Exc; Exc held until ExcAck; no nesting while in handler.
// Optional IRQ_MASK_EN adds a per-channel enable mask (mask_we/mask_wdata) applied to arbitration.
module exc_irq_controller #(
  parameter  int N_IRQ     = 4,
  parameter  int ESTATUS_W = 4,
  localparam int ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef IRQ_MASK_EN
  input  logic                 mask_we,
  input  logic [N_IRQ-1:0]     mask_wdata,
`endif
  input  logic [N_IRQ-1:0]     ExtIRQ,
  input  logic                 SyncExc,
  input  logic [ESTATUS_W-1:0] SyncCode,
  input  logic                 ERet,
  input  logic                 ExcAck,
  output logic                 Exc,
  output logic [ESTATUS_W-1:0] EStatus,
  output logic [N_IRQ-1:0]     ExtIAck,
  output logic [ID_W-1:0]      IrqId,
  output logic                 InHandler
);

  localparam int CODE_W = ESTATUS_W - 1;

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

  state_t                 state_q, state_d;
  logic [N_IRQ-1:0]       pending_q, pending_d;
  logic [N_IRQ-1:0]       enabled;
  logic [N_IRQ-1:0]       ack_d;
  logic                   exc_d;
  logic                   in_handler_d;
  logic [ESTATUS_W-1:0]   estatus_d;
  logic [ID_W-1:0]        irq_id_d;
  logic [ID_W-1:0]        arb_id;
  logic                   arb_vld;

`ifdef IRQ_MASK_EN
  logic [N_IRQ-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (!reset)
      mask_q <= '1;
    else if (mask_we)
      mask_q <= mask_wdata;
  end

  // Masked channels keep latching; the mask only hides them from arbitration.
  assign enabled = (pending_q | ExtIRQ) & mask_q;
`else
  assign enabled = pending_q | ExtIRQ;
`endif

  // Lowest index wins: scan downward so the last hit is the smallest channel.
  always_comb begin
    arb_vld = 1'b0;
    arb_id  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        arb_vld = 1'b1;
        arb_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    exc_d        = Exc;
    estatus_d    = EStatus;
    irq_id_d     = IrqId;
    in_handler_d = InHandler;
    ack_d        = '0;
    case (state_q)
      IDLE: begin
        if (SyncExc) begin
          state_d   = REQ;
          exc_d     = 1'b1;
          estatus_d = SyncCode;
        end else if (arb_vld) begin
          state_d   = REQ;
          exc_d     = 1'b1;
          estatus_d = {1'b1, CODE_W'(arb_id)};
          irq_id_d  = arb_id;
        end
      end
      REQ: begin
        if (ExcAck) begin
          state_d      = HANDLER;
          exc_d        = 1'b0;
          in_handler_d = 1'b1;
          if (EStatus[ESTATUS_W-1])
            ack_d = N_IRQ'(1) << IrqId;
        end
      end
      HANDLER: begin
        if (ERet) begin
          state_d      = IDLE;
          in_handler_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The ack clears its channel on the same edge it is raised, overriding a new set.
  assign pending_d = (pending_q | ExtIRQ) & ~ack_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      Exc       <= 1'b0;
      EStatus   <= '0;
      ExtIAck   <= '0;
      IrqId     <= '0;
      InHandler <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      Exc       <= exc_d;
      EStatus   <= estatus_d;
      ExtIAck   <= ack_d;
      IrqId     <= irq_id_d;
      InHandler <= in_handler_d;
    end
  end

endmodule

// File: tb/tb_exc_irq_controller.sv
// Directed bench for exc_irq_controller with a cycle model and literal spot checks.
module tb_exc_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ExtIRQ;
  logic       SyncExc;
  logic [3:0] SyncCode;
  logic       ERet;
  logic       ExcAck;
  logic       Exc;
  logic [3:0] EStatus;
  logic [3:0] ExtIAck;
  logic [1:0] IrqId;
  logic       InHandler;
`ifdef IRQ_MASK_EN
  logic       mask_we;
  logic [3:0] mask_wdata;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  exc_irq_controller #(.N_IRQ(4), .ESTATUS_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef IRQ_MASK_EN
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
`endif
    .ExtIRQ    (ExtIRQ),
    .SyncExc   (SyncExc),
    .SyncCode  (SyncCode),
    .ERet      (ERet),
    .ExcAck    (ExcAck),
    .Exc       (Exc),
    .EStatus   (EStatus),
    .ExtIAck   (ExtIAck),
    .IrqId     (IrqId),
    .InHandler (InHandler)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: "request outstanding" / "inside handler" flags plus a pending set.
  bit         model_valid = 0;
  bit         m_req = 0, m_hnd = 0;
  logic [3:0] m_est = 0, m_ack = 0, m_pend = 0, m_mask = 4'hF;
  logic [1:0] m_id = 0;

  always @(posedge clk) begin
    logic [3:0] avail;
    logic [3:0] ack;
    if (!reset) begin
      m_req = 0; m_hnd = 0; m_est = 0; m_ack = 0; m_pend = 0; m_id = 0; m_mask = 4'hF;
    end else begin
      ack   = 0;
      avail = (m_pend | ExtIRQ) & m_mask;
      if (m_req) begin
        if (ExcAck) begin
          m_req = 0; m_hnd = 1;
          if (m_est >= 8) ack = 4'd1 << m_id;
        end
      end else if (m_hnd) begin
        if (ERet) m_hnd = 0;
      end else if (SyncExc) begin
        m_req = 1; m_est = SyncCode;
      end else if (avail != 0) begin
        for (int i = 3; i >= 0; i--) if (avail[i]) m_id = 2'(i);
        m_req = 1; m_est = 4'(8 + m_id);
      end
      m_pend = (m_pend | ExtIRQ) & ~ack;
      m_ack  = ack;
`ifdef IRQ_MASK_EN
      if (mask_we) m_mask = mask_wdata;
`endif
    end
    model_valid = 1;
  end

  always @(negedge clk)
    if (model_valid)
      check("cycle{Exc,EStatus,ExtIAck,IrqId,InHandler}",
            {20'd0, Exc, EStatus, ExtIAck, IrqId, InHandler},
            {20'd0, m_req, m_est, m_ack, m_id, m_hnd});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; ExtIRQ = 4'hF; SyncExc = 0; SyncCode = 0; ERet = 0; ExcAck = 0;
`ifdef IRQ_MASK_EN
    mask_we = 0; mask_wdata = 0;
`endif
    // Reset with all requests raised
    step(); step();
    check("reset_outputs", {Exc, EStatus, ExtIAck, IrqId, InHandler}, 12'h000);
    reset = 1; ExtIRQ = 0;
    step(); step();
    check("reset_pending_dropped", Exc, 0);

    // Single IRQ on channel 2, ERet ignored while requesting
    ExtIRQ = 4'b0100; step();
    check("irq2_exc", Exc, 1);
    check("irq2_estatus", EStatus, 4'b1010);
    check("irq2_id", IrqId, 2);
    ExtIRQ = 0; ERet = 1; step();
    ERet = 0; step();
    check("req_hold", Exc, 1);
    ExcAck = 1; step();
    check("irq2_ack", {Exc, ExtIAck, InHandler}, {1'b0, 4'b0100, 1'b1});
    ExcAck = 1; step();
    check("ack_one_cycle", ExtIAck, 0);
    ExcAck = 0; ERet = 1; step();
    check("eret_exit", InHandler, 0);
    ERet = 0; step(); step();
    check("irq2_no_repend", Exc, 0);

    // Sync exception beats simultaneous IRQs, then ch1 then ch3
    SyncExc = 1; SyncCode = 4'h3; ExtIRQ = 4'b1010; step();
    check("sync_priority", EStatus, 4'h3);
    SyncExc = 0; ExtIRQ = 0; ExcAck = 1; step();
    check("sync_no_devack", ExtIAck, 0);
    ExcAck = 0; ERet = 1; step();
    check("no_take_on_eret", Exc, 0);
    ERet = 0; step();
    check("ch1_next", {Exc, EStatus}, {1'b1, 4'b1001});
    ExcAck = 1; step();
    check("ch1_ack", ExtIAck, 4'b0010);
    ExcAck = 0; ERet = 1; step();
    ERet = 0; step();
    check("ch3_next", {Exc, EStatus, IrqId}, {1'b1, 4'b1011, 2'd3});
    ExcAck = 1; step();

    // No nesting: IRQ0 while in handler waits for IDLE
    ExcAck = 0; ExtIRQ = 4'b0001; SyncExc = 1; SyncCode = 4'h5; step();
    ExtIRQ = 0; SyncExc = 0; step();
    check("no_nest", Exc, 0);
    ERet = 1; step();
    check("no_nest_eret", Exc, 0);
    ERet = 0; step();
    check("ch0_after_return", {Exc, EStatus}, {1'b1, 4'b1000});
    ExcAck = 1; step();
    ExcAck = 0; ERet = 1; step();
    ERet = 0;

    // Device drops request in the ack cycle: clear wins, no re-entry
    ExtIRQ = 4'b0100; step();
    ExcAck = 1; step();
    ExcAck = 0; ExtIRQ = 0; ERet = 1; step();
    ERet = 0; step(); step();
    check("clear_beats_set", Exc, 0);

    // Device holds request through the ack cycle: re-pended
    ExtIRQ = 4'b0100; step();
    ExcAck = 1; step();
    ExcAck = 0; step();
    ExtIRQ = 0; ERet = 1; step();
    ERet = 0; step();
    check("repend_held", {Exc, EStatus}, {1'b1, 4'b1010});
    ExcAck = 1; step();
    ExcAck = 0; ERet = 1; step();
    ERet = 0;

    // Reset while requesting
    ExtIRQ = 4'b0001; step();
    check("pre_reset_req", Exc, 1);
    ExtIRQ = 0; reset = 0; ExcAck = 1; step();
    check("reset_mid_req", {Exc, ExtIAck}, 5'b0);
    reset = 1; ExcAck = 0; step();
    check("reset_no_ack", ExtIAck, 0);
    step();
    check("reset_pending_clear", Exc, 0);

`ifdef IRQ_MASK_EN
    mask_we = 1; mask_wdata = 4'b1110; step();
    mask_we = 0; ExtIRQ = 4'b0001; step();
    ExtIRQ = 0; step();
    check("masked_no_exc", Exc, 0);
    mask_we = 1; mask_wdata = 4'hF; step();
    mask_we = 0; step();
    check("unmask_exc", {Exc, EStatus}, {1'b1, 4'b1000});
    ExcAck = 1; step();
    ExcAck = 0; ERet = 1; step();
    ERet = 0;
`endif

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
